// File: rtl/mul_arb_pkg.sv
// rtl/mul_arb_pkg.sv - shared states, ALU_Select codes and defaults for mul_arbiter
package mul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [4:0] MUL_LO   = 5'b10001;
  localparam logic [4:0] MULH_S   = 5'b11111;
  localparam logic [4:0] MULH_ALT = 5'b10111;

  localparam int DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/mul_arbiter_rr_pick.sv
// rtl/mul_arbiter_rr_pick.sv - combinational round-robin picker, priority starts at ptr
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  int   j;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - round-robin sharing of one iterative multiplier among N requesters
// Optional watchdog abort: MUL_ARBITER_WATCHDOG_EN
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int N              = 2,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [32*N-1:0] req_x,
  input  logic [32*N-1:0] req_y,
  input  logic [5*N-1:0]  req_sel,
  input  logic [N-1:0]    req_sign,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    rsp_valid,
  output logic [31:0]     rsp_data,
  output logic            rsp_err,
  output logic            mul_start,
  output logic [31:0]     mul_x,
  output logic [31:0]     mul_y,
  output logic [4:0]      mul_sel,
  output logic            mul_sign,
  input  logic            mul_busy,
  input  logic [31:0]     mul_z
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic [N-1:0]  pick_gnt;
  logic [IW-1:0] pick_idx;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

`ifdef MUL_ARBITER_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt;
  logic          wd_hit;
  // Fires on the edge that would take the count to TIMEOUT_CYCLES.
  assign wd_hit = (state == ISSUE || state == RUN) && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      mul_start <= 1'b0;
      mul_x     <= '0;
      mul_y     <= '0;
      mul_sel   <= '0;
      mul_sign  <= 1'b0;
`ifdef MUL_ARBITER_WATCHDOG_EN
      rsp_err   <= 1'b0;
      wd_cnt    <= '0;
`endif
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
`ifdef MUL_ARBITER_WATCHDOG_EN
      if (state == ISSUE || state == RUN) wd_cnt <= wd_cnt + CW'(1);
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            owner     <= pick_idx;
            gnt       <= pick_gnt;
            mul_x     <= req_x[int'(pick_idx)*32 +: 32];
            mul_y     <= req_y[int'(pick_idx)*32 +: 32];
            mul_sel   <= req_sel[int'(pick_idx)*5 +: 5];
            mul_sign  <= req_sign[pick_idx];
            mul_start <= 1'b1;
            state     <= ISSUE;
`ifdef MUL_ARBITER_WATCHDOG_EN
            wd_cnt    <= '0;
`endif
          end
        end
        ISSUE: begin
`ifdef MUL_ARBITER_WATCHDOG_EN
          if (wd_hit) begin
            mul_start <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= N'(1) << owner;
            state     <= RESP;
          end else
`endif
          if (mul_busy) begin
            mul_start <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
`ifdef MUL_ARBITER_WATCHDOG_EN
          if (wd_hit) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= N'(1) << owner;
            state     <= RESP;
          end else
`endif
          if (!mul_busy) begin
            rsp_data  <= mul_z;
            rsp_valid <= N'(1) << owner;
            state     <= RESP;
          end
        end
        RESP: begin
          ptr   <= (owner == IW'(N - 1)) ? '0 : owner + 1'b1;
          state <= IDLE;
`ifdef MUL_ARBITER_WATCHDOG_EN
          rsp_err <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - directed vector bench for mul_arbiter with a behavioural multiplier
module tb_mul_arbiter;
  import mul_arb_pkg::*;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [32*N-1:0] req_x = '0;
  logic [32*N-1:0] req_y = '0;
  logic [5*N-1:0]  req_sel = '0;
  logic [N-1:0]    req_sign = '0;
  logic [N-1:0]    gnt, rsp_valid;
  logic [31:0]     rsp_data, mul_x, mul_y, mul_z;
  logic            rsp_err, mul_start, mul_sign, mul_busy;
  logic [4:0]      mul_sel;

  always #5 clk = ~clk;

  mul_arbiter #(.N(N), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_x(req_x), .req_y(req_y),
    .req_sel(req_sel), .req_sign(req_sign), .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .mul_start(mul_start), .mul_x(mul_x),
    .mul_y(mul_y), .mul_sel(mul_sel), .mul_sign(mul_sign), .mul_busy(mul_busy),
    .mul_z(mul_z)
  );

  // Behavioural iterative multiplier: busy for mul_lat+1 cycles after start; not reset.
  logic        stuck = 1'b0;
  int          mul_lat = 3;
  int          mcnt = 0;
  logic        mbusy = 1'b0;
  logic [31:0] mz = '0;
  assign mul_busy = mbusy;
  assign mul_z    = mz;

  function automatic logic [31:0] mul_prod(logic [31:0] x, logic [31:0] y, logic [4:0] sel, logic sgn);
    logic [63:0] a, b, p;
    a = {{32{sgn & x[31]}}, x};
    b = {{32{sgn & y[31]}}, y};
    p = a * b;
    return (sel == MUL_LO) ? p[31:0] : p[63:32];
  endfunction

  always @(posedge clk) begin
    if (stuck) begin
      mbusy <= 1'b1;
      mcnt  <= 0;
    end else if (mbusy) begin
      if (mcnt == 0) mbusy <= 1'b0;
      else mcnt <= mcnt - 1;
    end else if (mul_start) begin
      mbusy <= 1'b1;
      mcnt  <= mul_lat;
      mz    <= mul_prod(mul_x, mul_y, mul_sel, mul_sign);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int oh_idx(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic set_slot(int i, logic [31:0] x, logic [31:0] y, logic [4:0] sel, logic sgn);
    req_x[i*32 +: 32] = x;
    req_y[i*32 +: 32] = y;
    req_sel[i*5 +: 5] = sel;
    req_sign[i]       = sgn;
  endtask

  task automatic wait_gnt(output int idx);
    idx = -1;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (gnt != '0) begin
        idx = oh_idx(gnt);
        return;
      end
    end
    check("gnt_timeout", 0, 1);
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = -1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (rsp_valid != '0) begin
        cyc = c;
        return;
      end
    end
    check("rsp_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    int          idx;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  sel;
    logic        sgn;
    int          lat;
    logic [31:0] z;
  } vec_t;

  vec_t vecs[6];
  int   exp_a[4];
  int   exp_b[5];

  initial begin
    int  g, cyc;
    bit  flag;

    vecs[0] = '{0, 32'd3,          32'hFFFF_FFFB, MUL_LO,   1'b1, 3, 32'hFFFF_FFF1};
    vecs[1] = '{2, 32'd7,          32'd6,         MUL_LO,   1'b0, 0, 32'h0000_002A};
    vecs[2] = '{1, 32'h0001_0000,  32'h0001_0000, MULH_S,   1'b1, 5, 32'h0000_0001};
    vecs[3] = '{3, 32'hFFFF_FFFF,  32'd2,         MULH_S,   1'b1, 1, 32'hFFFF_FFFF};
    vecs[4] = '{0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, MULH_ALT, 1'b0, 2, 32'hFFFF_FFFE};
    vecs[5] = '{3, 32'h8000_0000,  32'h8000_0000, MULH_S,   1'b1, 4, 32'h4000_0000};
    exp_a = '{1, 3, 1, 3};
    exp_b = '{0, 1, 2, 3, 0};

    // Reset state
    tick();
    tick();
    check("rst_gnt_rsp", {gnt, rsp_valid, rsp_err, mul_start}, 0);
    check("rst_regs", {mul_x, mul_y, mul_sel, mul_sign, rsp_data}, 0);
    rst_n = 1'b1;
    tick();

    // Single operations from the vector table
    for (int v = 0; v < 6; v++) begin
      mul_lat = vecs[v].lat;
      set_slot(vecs[v].idx, vecs[v].x, vecs[v].y, vecs[v].sel, vecs[v].sgn);
      req[vecs[v].idx] = 1'b1;
      wait_gnt(g);
      req = '0;
      check($sformatf("v%0d_gnt", v), gnt, N'(1) << vecs[v].idx);
      check($sformatf("v%0d_ops", v), {mul_x, mul_y, mul_sel, mul_sign, mul_start},
            {vecs[v].x, vecs[v].y, vecs[v].sel, vecs[v].sgn, 1'b1});
      wait_rsp(cyc);
      check($sformatf("v%0d_lat", v), cyc, vecs[v].lat + 3);
      check($sformatf("v%0d_rsp", v), {rsp_valid, rsp_data, rsp_err},
            {N'(1) << vecs[v].idx, vecs[v].z, 1'b0});
      tick();
      check($sformatf("v%0d_rsp_pulse", v), {rsp_valid, gnt}, 0);
    end

    // Contention 1010 held from reset
    mul_lat = 1;
    do_reset();
    set_slot(1, 32'd2, 32'd3, MUL_LO, 1'b0);
    set_slot(3, 32'd4, 32'd5, MUL_LO, 1'b0);
    req = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(g);
      check($sformatf("rr1010_%0d", k), g, exp_a[k]);
    end
    req = '0;
    wait_rsp(cyc);

    // Contention 1111 held from reset
    do_reset();
    set_slot(0, 32'd1, 32'd1, MUL_LO, 1'b0);
    set_slot(2, 32'd6, 32'd7, MUL_LO, 1'b0);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(g);
      check($sformatf("rr1111_%0d", k), g, exp_b[k]);
    end
    req = '0;
    wait_rsp(cyc);

    // Request arriving while owner 0 is in RUN
    do_reset();
    mul_lat = 6;
    set_slot(0, 32'd11, 32'd3, MUL_LO, 1'b0);
    set_slot(2, 32'd9, 32'd9, MUL_LO, 1'b0);
    req = 4'b0001;
    wait_gnt(g);
    req = '0;
    check("run_first_gnt", g, 0);
    for (int c = 0; c < 10 && !mul_busy; c++) tick();
    tick();
    req[2] = 1'b1;
    flag = 1'b0;
    cyc = 0;
    while (rsp_valid == '0 && cyc < 50) begin
      tick();
      cyc++;
      if (gnt != '0) flag = 1'b1;
    end
    check("run_no_early_gnt", flag, 0);
    check("run_rsp0", {rsp_valid, rsp_data}, {4'b0001, 32'd33});
    tick();
    check("run_idle_gap", gnt, 0);
    tick();
    check("run_gnt2", gnt, 4'b0100);
    req = '0;
    wait_rsp(cyc);
    check("run_rsp2", {rsp_valid, rsp_data}, {4'b0100, 32'd81});

    // Reset during RUN
    tick();
    mul_lat = 8;
    set_slot(1, 32'h1234_5678, 32'd9, MUL_LO, 1'b1);
    req = 4'b0010;
    wait_gnt(g);
    req = '0;
    for (int c = 0; c < 10 && !mul_busy; c++) tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ctl", {gnt, rsp_valid, rsp_err, mul_start}, 0);
    check("midrst_regs", {mul_x, mul_y, mul_sel, mul_sign, rsp_data}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    flag = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (rsp_valid != '0) flag = 1'b1;
    end
    check("midrst_no_rsp", flag, 0);
    mul_lat = 2;
    set_slot(1, 32'd5, 32'd7, MUL_LO, 1'b0);
    req = 4'b0010;
    wait_gnt(g);
    req = '0;
    check("midrst_next_gnt", g, 1);
    wait_rsp(cyc);
    check("midrst_next_rsp", {rsp_valid, rsp_data, rsp_err}, {4'b0010, 32'd35, 1'b0});

    // Stuck multiplier
    tick();
    stuck = 1'b1;
    tick();
    set_slot(3, 32'd1, 32'd2, MUL_LO, 1'b0);
    req = 4'b1000;
    wait_gnt(g);
    req = '0;
`ifdef MUL_ARBITER_WATCHDOG_EN
    wait_rsp(cyc);
    check("wd_cycles", cyc, 16);
    check("wd_rsp", {rsp_valid, rsp_err, rsp_data, mul_start}, {4'b1000, 1'b1, 32'd0, 1'b0});
    tick();
    check("wd_pulse", rsp_valid, 0);
    tick();
    tick();
    check("wd_idle", {gnt, mul_start}, 0);
    stuck = 1'b0;
`else
    flag = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (rsp_valid != '0) flag = 1'b1;
    end
    check("stuck_no_rsp", flag, 0);
    check("stuck_err0", rsp_err, 0);
    rst_n = 1'b0;
    tick();
    stuck = 1'b0;
    tick();
    rst_n = 1'b1;
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Round-robin controller that shares one iterative Booth multiplier among N requesters. It accepts level requests with operands, issues one multiply at a time through the multiplier's start/busy handshake, and captures the result. It returns the result to the owning requester with a one-cycle valid pulse. It sits between the ALU-side requesters (core pipeline, DSP helpers) and the single multiplier instance.

## Interface
- N, 2, number of requesters (2..8)
- TIMEOUT_CYCLES, 64, watchdog limit in cycles; only used when the watchdog is compiled in
- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  reset, asynchronous and active-low
- req  in  N  per-requester request level
- req_x  in  32*N  multiplicand per requester; slot i is [32i+31:32i]
- req_y  in  32*N  multiplier per requester
- req_sel  in  5*N  ALU_Select code per requester
- req_sign  in  N  signed-operation flag per requester
- gnt  out  N  one-hot, one-cycle pulse when a requester's operands are latched
- rsp_valid  out  N  one-hot, one-cycle pulse when the result is available
- rsp_data  out  32  result; valid only while any rsp_valid bit is 1
- rsp_err  out  1  watchdog abort flag, qualified by rsp_valid; tied 0 when the watchdog is not compiled in
- mul_start  out  1  start to the multiplier
- mul_x, mul_y  out  32 each  latched operands
- mul_sel  out  5  latched ALU_Select
- mul_sign  out  1  latched sign
- mul_busy  in  1  multiplier busy
- mul_z  in  32  multiplier result (Z1)

## Operation
- States: IDLE, ISSUE, RUN, RESP.
- **IDLE**
  - If any req bit is set, the round-robin picker chooses an owner.
  - Its req_x, req_y, req_sel and req_sign are latched into the mul_* registers.
  - gnt[owner] pulses; next state is ISSUE.
- **ISSUE**
  - mul_start is 1.
  - When mul_busy=1, mul_start drops and the next state is RUN.
- **RUN**
  - When mul_busy=0, mul_z is captured into rsp_data and the next state is RESP.
- **RESP**
  - rsp_valid[owner] pulses.
  - The priority pointer moves to owner+1 (mod N).
  - Next state is IDLE.
- Round-robin rule:
  - The highest priority is the pointer index, then ascending indices with wrap-around.
  - After reset the pointer is 0.
- Requester rule:
  - Hold req and operands stable until gnt.
  - Deassert req in the cycle after gnt, unless a new operation is wanted.
  - req still high when the arbiter returns to IDLE is treated as a new request.
- Operand and result paths:
  - Operands pass through unmodified; no width conversion.
  - rsp_data is mul_z verbatim. Low/high word and sign fixup are the multiplier's job, selected by mul_sel/mul_sign.
- A req bit dropping while not granted is ignored; there is no cancel.
- Requests arriving in ISSUE/RUN/RESP wait; they are arbitrated in the next IDLE cycle.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE and the pointer to 0.
  - gnt, rsp_valid, rsp_err and mul_start are 0.
  - mul_x, mul_y, rsp_data and mul_sel are 0; mul_sign is 0.
- Reset mid-operation: the in-flight request is dropped and no rsp_valid is produced. The multiplier finishes on its own; a stale mul_busy is ignored because the arbiter waits in IDLE.
- Cycle timing:
  - gnt is registered and appears the cycle after req is sampled high in IDLE.
  - mul_start rises with the ISSUE entry.
  - rsp_valid appears one cycle after mul_busy is seen falling in RUN.
- Overhead is 3 cycles plus the multiplier busy period. Back-to-back service has one IDLE cycle between rsp_valid and the next gnt.

## Configuration
- MUL_ARBITER_WATCHDOG_EN defined:
  - A counter clears on ISSUE entry and increments in ISSUE/RUN.
  - When it reaches TIMEOUT_CYCLES, the arbiter jumps to RESP with rsp_err=1 and rsp_data=0.
  - mul_start drops on the abort.
- Not defined: no counter, rsp_err is constant 0, and a stuck mul_busy hangs the arbiter.

## Structure
- Shared package mul_arb_pkg:
  - State enum.
  - ALU_Select constants: MUL_LO=5'b10001, MULH signed 5'b11111, 5'b10111.
  - Default TIMEOUT_CYCLES.
- One sub-module, rr_pick: combinational N-bit round-robin priority picker (req, pointer -> one-hot grant, index).

## Test plan
- Single request: req[0], X=3, Y=-5, sel=10001, with the behavioural multiplier model returning -15. Required: gnt[0] for one cycle, mul_x=3, mul_y=0xFFFFFFFB, then rsp_valid[0] with rsp_data=0xFFFFFFF1 and rsp_err=0.
- Contention, N=4, req=4'b1010 held continuously from reset: grants in order 1, 3, 1, 3. With req=4'b1111: grants 0, 1, 2, 3, 0.
- Request during RUN: req[2] rises while owner 0 is busy. Required: no gnt until after rsp_valid[0], then gnt[2] after exactly one IDLE cycle.
- Reset mid-operation: rst_n low during RUN. Required: all outputs 0 immediately, no rsp_valid afterwards, and the next req[1] is served normally.
- With MUL_ARBITER_WATCHDOG_EN and TIMEOUT_CYCLES=16, mul_busy stuck at 1. Required: rsp_valid[owner] with rsp_err=1 and rsp_data=0 at cycle 16 after ISSUE entry, then a return to IDLE.
